prbs_tx_ctrl: RTL and testbench

Sequencer for the pair of PRBS9 generators (I and Q) that feed the QPSK transmit path.
- Produces the shared generator enable strobe at symbol rate (one pulse every OS_FACTOR clocks).
- Issues a synchronous reseed pulse before each run.
- Supports burst and continuous modes, and counts emitted symbols.
- Sits between the host control registers and the two generator instances.

---
 rtl/prbs_ctrl_pkg.sv | 14 +
 rtl/sym_strobe_gen.sv | 34 +++
 rtl/prbs_tx_ctrl.sv | 88 ++++++++
 tb/tb_prbs_tx_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared definitions for the QPSK PRBS generator sequencer.
package prbs_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OS_FACTOR_DEF = 4;
  localparam int BURST_W_DEF   = 16;

endpackage

// File: rtl/sym_strobe_gen.sv
// Symbol-rate phase counter; strobe is a flop that is high while phase == OS_FACTOR-1.
module sym_strobe_gen #(
  parameter int OS_FACTOR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic strobe
);

  localparam int            PW      = $clog2(OS_FACTOR);
  localparam logic [PW-1:0] PH_LAST = PW'(OS_FACTOR - 1);
  localparam logic [PW-1:0] PH_PRE  = PW'(OS_FACTOR - 2);

  logic [PW-1:0] phase;

  // Strobe is set one edge early so it lines up with phase == PH_LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= '0;
      strobe <= 1'b0;
    end else if (clr) begin
      phase  <= '0;
      strobe <= 1'b0;
    end else if (run) begin
      phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      strobe <= (phase == PH_PRE);
    end else begin
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/prbs_tx_ctrl.sv
// Sequencer for the I/Q PRBS9 generators: reseed, symbol-rate enable, burst/continuous runs.
module prbs_tx_ctrl
  import prbs_ctrl_pkg::*;
#(
  parameter int OS_FACTOR = OS_FACTOR_DEF,
  parameter int BURST_W   = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_continuous,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_prbs_load,
  output logic               o_prbs_en,
  output logic               o_sym_valid,
  output logic [BURST_W-1:0] o_sym_cnt,
  output logic               o_busy,
  output logic               o_done
);

  state_t             state, state_nxt;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] cnt_inc;
  logic               cont_q;
  logic               stop_pend;
  logic               start_ok;
  logic               burst_end;

  assign start_ok  = (state == IDLE) && i_start;
  assign cnt_inc   = o_sym_cnt + 1'b1;
  assign burst_end = !cont_q && (cnt_inc == len_q);

  sym_strobe_gen #(.OS_FACTOR(OS_FACTOR)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .run    (state == RUN),
    .strobe (o_prbs_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = LOAD;
      LOAD: state_nxt = (!cont_q && len_q == '0) ? DONE : RUN;
      // Stop and burst end both wait for an enable, so a coincident pair is one exit.
      RUN:  if (o_prbs_en && (stop_pend || burst_end)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend   <= 1'b0;
      o_sym_cnt   <= '0;
      o_prbs_load <= 1'b0;
      o_sym_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q  <= i_burst_len;
        cont_q <= i_continuous;
      end

      if (start_ok || state != RUN) stop_pend <= 1'b0;
      else if (i_stop)              stop_pend <= 1'b1;

      if (start_ok)       o_sym_cnt <= '0;
      else if (o_prbs_en) o_sym_cnt <= cnt_inc;

      o_prbs_load <= (state_nxt == LOAD);
      o_busy      <= (state_nxt == LOAD) || (state_nxt == RUN);
      o_done      <= (state_nxt == DONE);
      o_sym_valid <= o_prbs_en;
    end
  end

endmodule

// File: tb/tb_prbs_tx_ctrl.sv
// Directed bench for prbs_tx_ctrl with OS_FACTOR=4; per-cycle output masks vs hand-derived values.
module tb_prbs_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_continuous = 1'b0;
  logic [15:0] i_burst_len = '0;
  logic        o_prbs_load, o_prbs_en, o_sym_valid, o_busy, o_done;
  logic [15:0] o_sym_cnt;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] m_load, m_en, m_val, m_busy, m_done;
  logic [15:0] cnt_end;

  prbs_tx_ctrl #(.OS_FACTOR(4), .BURST_W(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_continuous(i_continuous), .i_burst_len(i_burst_len),
    .o_prbs_load(o_prbs_load), .o_prbs_en(o_prbs_en), .o_sym_valid(o_sym_valid),
    .o_sym_cnt(o_sym_cnt), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start at cycle 0, then record outputs for cycles 1..31 (sampled on negedge).
  task automatic run_burst(input logic [15:0] len, input logic cont,
                           input int stop_cyc, input int restart_cyc);
    m_load = '0; m_en = '0; m_val = '0; m_busy = '0; m_done = '0;
    @(negedge clk);
    i_start = 1'b1; i_burst_len = len; i_continuous = cont;
    i_stop = (stop_cyc == 0);
    for (int c = 1; c < 32; c++) begin
      @(posedge clk);
      @(negedge clk);
      m_load[c] = o_prbs_load; m_en[c] = o_prbs_en; m_val[c] = o_sym_valid;
      m_busy[c] = o_busy;      m_done[c] = o_done;
      i_start = (c == restart_cyc);
      i_burst_len = (c == restart_cyc) ? 16'd2 : len;
      i_stop  = (c == stop_cyc);
    end
    cnt_end = o_sym_cnt;
    i_start = 1'b0; i_stop = 1'b0; i_continuous = 1'b0;
  endtask

  initial begin
    int nen;
    int c10;
    int c11;
    int cdone;
    int anyout;

    // Reset held, with a start request pending: everything must stay cleared.
    i_start = 1'b1; i_burst_len = 16'd3;
    repeat (3) @(negedge clk);
    chk("rst_outs", {27'd0, o_prbs_load, o_prbs_en, o_sym_valid, o_busy, o_done}, 32'd0);
    chk("rst_cnt", {16'd0, o_sym_cnt}, 32'd0);
    i_start = 1'b0;
    rst = 1'b1;
    nen = 0; anyout = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_prbs_en) nen++;
      if (o_prbs_load || o_sym_valid || o_busy || o_done || o_sym_cnt != 0) anyout++;
    end
    chk("idle_en_count", nen, 0);
    chk("idle_any_out", anyout, 0);

    // Short burst of 3.
    run_burst(16'd3, 1'b0, -1, -1);
    chk("b3_load", m_load, 32'h0000_0002);
    chk("b3_en",   m_en,   32'h0000_2220);
    chk("b3_val",  m_val,  32'h0000_4440);
    chk("b3_done", m_done, 32'h0000_4000);
    chk("b3_busy", m_busy, 32'h0000_3FFE);
    chk("b3_cnt",  cnt_end, 32'd3);

    // Zero-length burst: LOAD, DONE, IDLE.
    run_burst(16'd0, 1'b0, -1, -1);
    chk("b0_load", m_load, 32'h0000_0002);
    chk("b0_en",   m_en,   32'h0000_0000);
    chk("b0_done", m_done, 32'h0000_0004);
    chk("b0_busy", m_busy, 32'h0000_0002);
    chk("b0_cnt",  cnt_end, 32'd0);

    // Start during RUN at cycle 7 (with a different length) is ignored.
    run_burst(16'd5, 1'b0, -1, 7);
    chk("rs_load", m_load, 32'h0000_0002);
    chk("rs_en",   m_en,   32'h0022_2220);
    chk("rs_val",  m_val,  32'h0044_4440);
    chk("rs_done", m_done, 32'h0040_0000);
    chk("rs_cnt",  cnt_end, 32'd5);

    // Stop in IDLE is dropped; the following burst runs to full length.
    @(negedge clk); i_stop = 1'b1;
    @(negedge clk); i_stop = 1'b0;
    repeat (3) @(negedge clk);
    run_burst(16'd2, 1'b0, -1, -1);
    chk("si_en",   m_en,   32'h0000_0220);
    chk("si_done", m_done, 32'h0000_0400);
    chk("si_cnt",  cnt_end, 32'd2);

    // Start and stop together in IDLE: start wins, stop is dropped.
    run_burst(16'd2, 1'b0, 0, -1);
    chk("ss_en",   m_en,   32'h0000_0220);
    chk("ss_done", m_done, 32'h0000_0400);
    chk("ss_cnt",  cnt_end, 32'd2);

    // Continuous mode, stop two cycles after the 10th enable -> 11 enables.
    @(negedge clk);
    i_start = 1'b1; i_continuous = 1'b1; i_burst_len = 16'd3;
    nen = 0; c10 = -1; c11 = -1; cdone = -1;
    for (int c = 1; c < 300 && cdone < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      if (o_prbs_en) begin
        nen++;
        if (nen == 10) c10 = c;
        if (nen == 11) c11 = c;
      end
      if (o_done) cdone = c;
      i_stop = (c10 >= 0 && c == c10 + 2);
    end
    i_stop = 1'b0; i_continuous = 1'b0;
    chk("ct_en_count", nen, 11);
    chk("ct_10th_cyc", c10, 41);
    chk("ct_done_cyc", cdone, 46);
    chk("ct_done_after_11th", cdone, c11 + 1);
    chk("ct_cnt", {16'd0, o_sym_cnt}, 32'd11);

    // Asynchronous reset between enables 2 and 3 (enables at 5, 9, 13).
    @(negedge clk);
    i_start = 1'b1; i_burst_len = 16'd5;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
    end
    chk("ar_pre_cnt", {16'd0, o_sym_cnt}, 32'd2);
    chk("ar_pre_busy", {31'd0, o_busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_outs", {27'd0, o_prbs_load, o_prbs_en, o_sym_valid, o_busy, o_done}, 32'd0);
    chk("ar_cnt", {16'd0, o_sym_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;
    nen = 0; anyout = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_prbs_en) nen++;
      if (o_done || o_busy) anyout++;
    end
    chk("ar_no_en", nen, 0);
    chk("ar_no_done", anyout, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
